anim_seq: RTL and testbench
===========================

Name: anim_seq

Overview:
- Player-sprite animation sequencer; sits directly downstream of the 60 Hz frame-tick generator.
- Consumes the one-cycle frame_tick pulse and the player movement/attack controls.
- Produces the animation state, the sprite frame index and the facing direction for the sprite-ROM address logic in the draw pipeline.
- All state advances only on frame_tick, so animation speed is independent of the 60 MHz clk.

Parameters:
- IDLE_FRAMES, 2, frames in the idle loop (1..4)
- IDLE_DIV, 30, frame_ticks per idle frame (1..63)
- WALK_FRAMES, 4, frames in the walk loop (1..4)
- WALK_DIV, 6, frame_ticks per walk frame (1..63)
- ATK_FRAMES, 4, frames in the attack sequence (1..4)
- ATK_DIV, 4, frame_ticks per attack frame (1..63)

Ports:
- clk  in  1  system clock, 60 MHz
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at 60 Hz
- move_left  in  1  level, left key held
- move_right  in  1  level, right key held
- on_ground  in  1  level, player standing on a tile
- attack_req  in  1  pulse or level, attack requested
- anim_state  out  2  current state (anim_state_t encoding)
- frame_idx  out  2  sprite frame within the current state
- facing_left  out  1  1 = mirror sprite horizontally
- attack_active  out  1  high while state is ATTACK
- attack_done  out  1  one-cycle pulse when an attack sequence finishes

Behaviour:
- **Clock and reset:** one clock, clk. Reset is synchronous and active-high on rst. Reset has priority over frame_tick.
- **Reset values:** anim_state=IDLE (0), frame_idx=0, facing_left=0, attack_active=0, attack_done=0, attack_pend=0, div_cnt=0.
- **State encoding:** IDLE=0, WALK=1, JUMP=2, ATTACK=3.
- **Attack request capture:**
  - attack_pend is set on any clk cycle with attack_req=1 while state≠ATTACK.
  - Requests arriving during ATTACK are dropped.
- **Registered inputs:** move_left, move_right and on_ground are sampled only on frame_tick cycles. All outputs are registered and update on the clk edge of the tick cycle.
- **Next-state priority on each tick, outside ATTACK:**
  1. attack_pend → ATTACK (clear attack_pend)
  2. !on_ground → JUMP
  3. move_left XOR move_right → WALK
  4. otherwise → IDLE
- **ATTACK is non-interruptible:** it stays until its final frame's final division completes, then exits on that same tick using priorities 2-4.
- **State change on a tick:** frame_idx←0 and div_cnt←0.
- **Same state on a tick:**
  - If div_cnt==DIV-1: div_cnt←0 and frame_idx←frame_idx+1, wrapping to 0 after FRAMES-1.
  - Otherwise div_cnt←div_cnt+1.
- **JUMP:** frame_idx is held at 0; div_cnt is frozen.
- **ATTACK exit:** at frame_idx==ATK_FRAMES-1 with div_cnt==ATK_DIV-1 on a tick:
  - exit ATTACK;
  - attack_done=1 for exactly that one clk cycle;
  - attack_active falls in the same cycle.
- **facing_left:** updated on ticks when state≠ATTACK and exactly one direction is held. move_left alone →1; move_right alone →0. Both or neither → hold.
- **Timing:** no output changes on non-tick cycles, except that attack_pend (internal) may set.
- **Counter width:** div_cnt is 6 bits; DIV=1 advances a frame every tick.
- **Mid-operation reset:** rst asserted during ATTACK aborts the sequence with no attack_done pulse.

Decomposition:
- Package anim_pkg holds:
  - typedef enum logic[1:0] anim_state_t {IDLE, WALK, JUMP, ATTACK};
  - FRAME_IDX_W=2;
  - DIV_W=6.
- Sub-module anim_frame_cnt holds the div_cnt/frame_idx pair.
  - Inputs: clk, rst, tick, restart, hold, frames, div.
  - Outputs: frame_idx, last (frame_idx==frames-1 and div_cnt==div-1).
- anim_seq holds the FSM, attack_pend and facing_left.

Test Plan:
- **Reset/idle:** assert rst with frame_tick pulsing, then release with no inputs → state 0, frame_idx 0. After 30 ticks frame_idx=1; after 60 ticks frame_idx=0.
- **Walk:** on_ground=1, move_right held. First tick → state 1, frame_idx 0. frame_idx reaches 1 after 6 more ticks, 3 after 18, and wraps to 0 after 24. facing_left stays 0.
- **Facing:** move_left alone for 1 tick → facing_left=1. Both keys held → state IDLE, facing_left stays 1.
- **Jump preemption:** during WALK frame 2, drop on_ground → state 2 and frame_idx 0 on the next tick. frame_idx stays 0 for 10 ticks.
- **Attack:**
  - Stimulus: 1-cycle attack_req between ticks with move_left held.
  - Next tick: state 3 and attack_active=1.
  - While in ATTACK: a second attack_req and a toggle of move_right are both ignored.
  - After 16 ticks: attack_done pulses for 1 cycle and state becomes WALK.
- **Reset mid-attack:** assert rst during ATTACK frame 2 → state IDLE, no attack_done pulse, attack_pend=0.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and widths for the player-sprite animation sequencer.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    JUMP   = 2'd2,
    ATTACK = 2'd3
  } anim_state_t;

  localparam int FRAME_IDX_W = 2;
  localparam int DIV_W       = 6;

endpackage

// File: rtl/anim_frame_cnt.sv
// Frame divider and frame index pair for one animation loop.
// Advances only on tick; restart zeroes both counters, hold freezes them.
module anim_frame_cnt
  import anim_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   restart,
  input  logic                   hold,
  input  logic [FRAME_IDX_W:0]   frames,
  input  logic [DIV_W-1:0]       div,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   last
);

  localparam logic [DIV_W-1:0]     DIV_ONE   = 1;
  localparam logic [FRAME_IDX_W:0] FRAME_ONE = 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_end;
  logic             frame_end;

  // Terminal-count decodes for the divider and the frame loop
  always_comb begin
    div_end   = (div_cnt == (div - DIV_ONE));
    frame_end = ({1'b0, frame_idx} == (frames - FRAME_ONE));
    last      = div_end && frame_end;
  end

  // Divider counts ticks within a frame; the frame index wraps after the last frame
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      frame_idx <= '0;
    end else if (tick) begin
      if (restart) begin
        div_cnt   <= '0;
        frame_idx <= '0;
      end else if (!hold) begin
        if (div_end) begin
          div_cnt   <= '0;
          frame_idx <= frame_end ? '0 : frame_idx + 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/anim_seq.sv
// Player-sprite animation sequencer. Everything advances on frame_tick so
// animation speed is independent of the system clock; the only activity
// between ticks is latching an attack request.
module anim_seq
  import anim_pkg::*;
#(
  parameter int unsigned IDLE_FRAMES = 2,
  parameter int unsigned IDLE_DIV    = 30,
  parameter int unsigned WALK_FRAMES = 4,
  parameter int unsigned WALK_DIV    = 6,
  parameter int unsigned ATK_FRAMES  = 4,
  parameter int unsigned ATK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   on_ground,
  input  logic                   attack_req,
  output anim_state_t            anim_state,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   facing_left,
  output logic                   attack_active,
  output logic                   attack_done
);

  localparam logic [FRAME_IDX_W:0] IDLE_FR = IDLE_FRAMES[FRAME_IDX_W:0];
  localparam logic [FRAME_IDX_W:0] WALK_FR = WALK_FRAMES[FRAME_IDX_W:0];
  localparam logic [FRAME_IDX_W:0] ATK_FR  = ATK_FRAMES[FRAME_IDX_W:0];
  localparam logic [DIV_W-1:0]     IDLE_DV = IDLE_DIV[DIV_W-1:0];
  localparam logic [DIV_W-1:0]     WALK_DV = WALK_DIV[DIV_W-1:0];
  localparam logic [DIV_W-1:0]     ATK_DV  = ATK_DIV[DIV_W-1:0];

  anim_state_t          next_state;
  anim_state_t          free_state;
  logic                 attack_pend;
  logic                 one_dir;
  logic                 cnt_restart;
  logic                 cnt_hold;
  logic                 cnt_last;
  logic [FRAME_IDX_W:0] cur_frames;
  logic [DIV_W-1:0]     cur_div;

  // Next-state selection: a pending attack wins, otherwise airborne, walking, idle;
  // an attack only yields once its final frame has fully elapsed
  always_comb begin
    one_dir = move_left ^ move_right;
    if (!on_ground)   free_state = JUMP;
    else if (one_dir) free_state = WALK;
    else              free_state = IDLE;

    next_state = anim_state;
    if (anim_state == ATTACK) begin
      if (cnt_last) next_state = free_state;
    end else if (attack_pend) begin
      next_state = ATTACK;
    end else begin
      next_state = free_state;
    end

    cnt_restart = (next_state != anim_state);
    cnt_hold    = (anim_state == JUMP);
  end

  // Loop length and frame rate for the current state
  always_comb begin
    cur_frames = IDLE_FR;
    cur_div    = IDLE_DV;
    case (anim_state)
      IDLE:    begin cur_frames = IDLE_FR; cur_div = IDLE_DV; end
      WALK:    begin cur_frames = WALK_FR; cur_div = WALK_DV; end
      ATTACK:  begin cur_frames = ATK_FR;  cur_div = ATK_DV;  end
      default: begin cur_frames = IDLE_FR; cur_div = IDLE_DV; end
    endcase
  end

  anim_frame_cnt u_frame_cnt (
    .clk       (clk),
    .rst       (rst),
    .tick      (frame_tick),
    .restart   (cnt_restart),
    .hold      (cnt_hold),
    .frames    (cur_frames),
    .div       (cur_div),
    .frame_idx (frame_idx),
    .last      (cnt_last)
  );

  // State register, attack request latch, facing and attack status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_state    <= IDLE;
      attack_pend   <= 1'b0;
      facing_left   <= 1'b0;
      attack_active <= 1'b0;
      attack_done   <= 1'b0;
    end else begin
      attack_done <= 1'b0;
      if (attack_req && anim_state != ATTACK) attack_pend <= 1'b1;
      if (frame_tick) begin
        anim_state    <= next_state;
        attack_active <= (next_state == ATTACK);
        if (anim_state != ATTACK && attack_pend) attack_pend <= 1'b0;
        if (anim_state == ATTACK && next_state != ATTACK) attack_done <= 1'b1;
        if (anim_state != ATTACK && one_dir) facing_left <= move_left;
      end
    end
  end

endmodule

// File: tb/tb_anim_seq.sv
// Directed bench for anim_seq: a vector table for the steady-state loops plus
// hand-written attack and reset sequences.
module tb_anim_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       on_ground;
  logic       attack_req;
  logic [1:0] anim_state;
  logic [1:0] frame_idx;
  logic       facing_left;
  logic       attack_active;
  logic       attack_done;

  int total = 0;
  int bad   = 0;

  anim_seq dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .move_left     (move_left),
    .move_right    (move_right),
    .on_ground     (on_ground),
    .attack_req    (attack_req),
    .anim_state    (anim_state),
    .frame_idx     (frame_idx),
    .facing_left   (facing_left),
    .attack_active (attack_active),
    .attack_done   (attack_done)
  );

  // 60 MHz-ish clock; exact period is irrelevant to the design
  always #8 clk = ~clk;

  typedef struct {
    string      name;
    logic       ml;
    logic       mr;
    logic       og;
    int         ticks;
    logic [1:0] st;
    logic [1:0] idx;
    logic       face;
  } vec_t;

  vec_t vecs[15];

  // One frame_tick pulse followed by one idle cycle; returns at a negedge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic checkOne(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] st, input logic [1:0] idx,
                             input logic face, input logic act, input logic done);
    checkOne({name, ".state"},  anim_state, st);
    checkOne({name, ".idx"},    frame_idx, idx);
    checkOne({name, ".facing"}, {1'b0, facing_left}, {1'b0, face});
    checkOne({name, ".active"}, {1'b0, attack_active}, {1'b0, act});
    checkOne({name, ".done"},   {1'b0, attack_done}, {1'b0, done});
  endtask

  task automatic pulseReq();
    @(negedge clk);
    attack_req = 1'b1;
    @(negedge clk);
    attack_req = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    on_ground  = 1'b1;
    attack_req = 1'b0;

    // name, ml, mr, og, ticks, state, idx, facing
    vecs[0]  = '{"idle29",     0, 0, 1, 29, 2'd0, 2'd0, 0};
    vecs[1]  = '{"idle30",     0, 0, 1,  1, 2'd0, 2'd1, 0};
    vecs[2]  = '{"idle60",     0, 0, 1, 30, 2'd0, 2'd0, 0};
    vecs[3]  = '{"walk_enter", 0, 1, 1,  1, 2'd1, 2'd0, 0};
    vecs[4]  = '{"walk5",      0, 1, 1,  5, 2'd1, 2'd0, 0};
    vecs[5]  = '{"walk6",      0, 1, 1,  1, 2'd1, 2'd1, 0};
    vecs[6]  = '{"walk18",     0, 1, 1, 12, 2'd1, 2'd3, 0};
    vecs[7]  = '{"walk24",     0, 1, 1,  6, 2'd1, 2'd0, 0};
    vecs[8]  = '{"face_left",  1, 0, 1,  1, 2'd1, 2'd0, 1};
    vecs[9]  = '{"both_keys",  1, 1, 1,  1, 2'd0, 2'd0, 1};
    vecs[10] = '{"walk_right", 0, 1, 1,  1, 2'd1, 2'd0, 0};
    vecs[11] = '{"walk_fr2",   0, 1, 1, 12, 2'd1, 2'd2, 0};
    vecs[12] = '{"jump_enter", 0, 1, 0,  1, 2'd2, 2'd0, 0};
    vecs[13] = '{"jump_hold",  0, 1, 0, 10, 2'd2, 2'd0, 0};
    vecs[14] = '{"land_idle",  0, 0, 1,  1, 2'd0, 2'd0, 0};

    // Reset held across frame ticks
    applyStimulus(2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 15; v++) begin
      move_left  = vecs[v].ml;
      move_right = vecs[v].mr;
      on_ground  = vecs[v].og;
      applyStimulus(vecs[v].ticks);
      checkOutput(vecs[v].name, vecs[v].st, vecs[v].idx, vecs[v].face, 1'b0, 1'b0);
    end

    // Attack: request between ticks, held left
    move_left = 1'b1;
    pulseReq();
    @(negedge clk);
    checkOutput("atk_no_tick", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("atk_enter", 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
    pulseReq();
    move_right = 1'b1;
    applyStimulus(8);
    checkOutput("atk_mid", 2'd3, 2'd2, 1'b1, 1'b1, 1'b0);
    move_right = 1'b0;
    applyStimulus(7);
    checkOutput("atk_last", 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checkOutput("atk_exit", 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("atk_done_drop", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("atk_req_dropped", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-attack: no done pulse, pending request cleared
    pulseReq();
    applyStimulus(1);
    checkOutput("atk2_enter", 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8);
    checkOutput("atk2_fr2", 2'd3, 2'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOne("rst_mid_done", {1'b0, attack_done}, 2'd0);
    end
    frame_tick = 1'b0;
    rst = 1'b0;
    move_left = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1);
    checkOutput("rst_pend_clear", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
